// File: rtl/uop_pkg.sv
// uop_pkg: shared types, opcodes and sizes for the micro-op sequencer and its table.
package uop_pkg;
  localparam int OP_W = 8;
  localparam int UOP_W = 32;
  localparam int UOP_MAX = 4;
  localparam int UOP_IDX_W = 2;
  localparam logic [OP_W-1:0] OP_I2B = 8'h91;
  localparam logic [OP_W-1:0] OP_RMW = 8'hA0;
  typedef enum logic [1:0] {IDLE, LOOKUP, SEND} state_t;
  typedef struct packed {
    logic valid;
    logic last;
    logic pass;
    logic [OP_W-1:0] out_op;
    logic [UOP_W-OP_W-1:0] imm;
  } uop_entry_t;
endpackage

// File: rtl/uop_rom.sv
// uop_rom: combinational micro-op table indexed by (opcode, uop index).
module uop_rom
  import uop_pkg::*;
(
  input  logic [OP_W-1:0]      opcode,
  input  logic [UOP_IDX_W-1:0] index,
  output uop_entry_t           entry
);
  always_comb begin
    case ({opcode, index})
      {OP_I2B, 2'd0}: entry = '{valid: 1'b1, last: 1'b1, pass: 1'b0, out_op: 8'h92, imm: 24'h0104E0};
      {OP_RMW, 2'd0}: entry = '{valid: 1'b1, last: 1'b0, pass: 1'b1, out_op: 8'hA1, imm: 24'h0};
      {OP_RMW, 2'd1}: entry = '{valid: 1'b1, last: 1'b0, pass: 1'b1, out_op: 8'hA2, imm: 24'h0};
      {OP_RMW, 2'd2}: entry = '{valid: 1'b1, last: 1'b1, pass: 1'b0, out_op: 8'hA3, imm: 24'h000010};
      default:        entry = '0;
    endcase
  end
endmodule

// File: rtl/uop_sequencer.sv
// uop_sequencer: expands a latched macro instruction into table-driven micro-ops,
// issuing one per memory handshake with flush, done and unknown-opcode error.
module uop_sequencer
  import uop_pkg::*;
#(
  parameter int BYTE      = OP_W,
  parameter int WIDTH_IN  = UOP_W,
  parameter int WIDTH_OUT = UOP_W,
  parameter int MAX_UOPS  = UOP_MAX,
  parameter int IDX_W     = UOP_IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 ready,
  input  logic [WIDTH_IN-1:0]  instruction_in,
  input  logic                 flush,
  output logic [WIDTH_OUT-1:0] instruction_out,
  output logic                 start_for_memory,
  input  logic                 ready_for_memory,
  output logic [IDX_W-1:0]     uop_index,
  output logic                 done,
  output logic                 error
);
  state_t state, state_n;
  logic [WIDTH_IN-1:0] latched;
  logic last;
  uop_entry_t entry;
  logic [WIDTH_OUT-1:0] uop_word;
  logic ready_n, sfm_n, done_n, error_n;
  uop_rom u_rom (
    .opcode(latched[WIDTH_IN-1 -: BYTE]),
    .index (uop_index),
    .entry (entry)
  );
  assign uop_word = {entry.out_op, entry.pass ? latched[WIDTH_IN-BYTE-1:0] : entry.imm};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      ready            <= 1'b1;
      instruction_out  <= '0;
      start_for_memory <= 1'b0;
      uop_index        <= '0;
      done             <= 1'b0;
      error            <= 1'b0;
      latched          <= '0;
      last             <= 1'b0;
    end else begin
      state            <= state_n;
      ready            <= ready_n;
      start_for_memory <= sfm_n;
      done             <= done_n;
      error            <= error_n;
      if (state == IDLE && start) begin
        latched   <= instruction_in;
        uop_index <= '0;
      end
      if (state == LOOKUP && entry.valid && !flush) begin
        instruction_out <= uop_word;
        last            <= entry.last || uop_index == IDX_W'(MAX_UOPS-1);
      end
      // last is forced at the final slot, so the increment can never wrap
      if (state == SEND && ready_for_memory && !last && !flush)
        uop_index <= uop_index + 1'b1;
    end
  end
  always_comb begin
    state_n = flush && state != IDLE ? IDLE :
              state == IDLE          ? (start ? LOOKUP : IDLE) :
              state == LOOKUP        ? (entry.valid ? SEND : IDLE) :
              ready_for_memory       ? (last ? IDLE : LOOKUP) : SEND;
  end
  always_comb begin
    ready_n = state_n == IDLE;
    sfm_n   = state_n == SEND;
    done_n  = state == SEND && ready_for_memory && last && !flush;
    error_n = state == LOOKUP && !entry.valid && !flush;
  end
endmodule

// File: tb/tb_uop_sequencer.sv
// tb_uop_sequencer: directed stimulus against a transaction-level model of the sequencer.
module tb_uop_sequencer;
  logic clk = 0, reset = 0, start = 0, flush = 0, ready_for_memory = 0;
  logic [31:0] instruction_in = 0;
  logic ready, start_for_memory, done, error;
  logic [31:0] instruction_out;
  logic [1:0] uop_index;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  uop_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .instruction_in(instruction_in), .flush(flush),
    .instruction_out(instruction_out), .start_for_memory(start_for_memory),
    .ready_for_memory(ready_for_memory), .uop_index(uop_index),
    .done(done), .error(error)
  );
  typedef logic [31:0] wq_t[$];
  wq_t log_q, m_words, exp_q;
  int done_cnt = 0, err_cnt = 0, sfm_cycles = 0, ack_delay = 0, wait_cnt = 0;
  logic s_valid = 0, s_rst = 0, s_start = 0, s_flush = 0, s_rfm = 0;
  logic [31:0] s_instr = 0;
  logic m_busy = 0, m_look = 0, m_req = 0, m_done = 0, m_err = 0;
  int m_pos = 0;
  bit found;
  // The micro-op program each macro instruction must produce; empty means unknown opcode
  function automatic wq_t expand(input logic [31:0] i);
    wq_t q;
    if (i[31:24] == 8'h91) q.push_back(32'h920104E0);
    else if (i[31:24] == 8'hA0) begin
      q.push_back({8'hA1, i[23:0]});
      q.push_back({8'hA2, i[23:0]});
      q.push_back(32'hA3000010);
    end
    return q;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_log(input string name);
    chk({name, "_len"}, log_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < log_q.size()) chk(name, log_q[i], exp_q[i]);
  endtask
  task automatic clear();
    log_q.delete(); exp_q.delete();
    done_cnt = 0; err_cnt = 0; sfm_cycles = 0;
  endtask
  initial forever begin
    @(posedge clk);
    s_valid = 1; s_rst = reset; s_start = start; s_flush = flush;
    s_rfm = ready_for_memory; s_instr = instruction_in;
    if (reset) begin
      if (start_for_memory) sfm_cycles++;
      if (start_for_memory && ready_for_memory && !flush) log_q.push_back(instruction_out);
      if (done) done_cnt++;
      if (error) err_cnt++;
    end
  end
  initial forever begin
    @(negedge clk);
    wait_cnt = start_for_memory ? wait_cnt + 1 : 0;
    ready_for_memory = wait_cnt >= ack_delay;
  end
  initial forever begin
    @(negedge clk);
    if (s_valid) begin
      if (!reset || !s_rst) begin
        m_busy = 0; m_look = 0; m_req = 0; m_done = 0; m_err = 0; m_pos = 0;
      end else begin
        m_done = 0; m_err = 0;
        if (!m_busy) begin
          if (s_start) begin
            m_busy = 1; m_words = expand(s_instr); m_pos = 0; m_look = 1;
          end
        end else if (s_flush) begin
          m_busy = 0; m_look = 0; m_req = 0;
        end else if (m_look) begin
          m_look = 0;
          if (m_words.size() == 0) begin m_err = 1; m_busy = 0; end
          else m_req = 1;
        end else if (m_req && s_rfm) begin
          m_req = 0; m_pos++;
          if (m_pos == m_words.size()) begin m_done = 1; m_busy = 0; end
          else m_look = 1;
        end
      end
      chk("ready", ready, m_busy ? 0 : 1);
      chk("start_for_memory", start_for_memory, m_req);
      chk("done", done, m_done);
      chk("error", error, m_err);
      if (m_req) begin
        chk("instruction_out", instruction_out, m_words[m_pos]);
        chk("uop_index", uop_index, 32'(m_pos));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1); chk("rst_sfm", start_for_memory, 0);
    chk("rst_out", instruction_out, 0); chk("rst_idx", uop_index, 0);
    chk("rst_done", done, 0); chk("rst_err", error, 0);
    reset = 1;
    @(negedge clk);
    clear(); ack_delay = 0; instruction_in = 32'h91000000; start = 1;
    @(negedge clk); start = 0;
    chk("t1_e_sfm", start_for_memory, 0); chk("t1_e_ready", ready, 0);
    @(negedge clk);
    chk("t1_e1_sfm", start_for_memory, 1); chk("t1_e1_out", instruction_out, 32'h920104E0);
    @(negedge clk);
    chk("t1_e2_sfm", start_for_memory, 0); chk("t1_e2_done", done, 1); chk("t1_e2_ready", ready, 1);
    repeat (3) @(negedge clk);
    exp_q.push_back(32'h920104E0); chk_log("t1_log");
    chk("t1_done_cnt", done_cnt, 1); chk("t1_sfm_cycles", sfm_cycles, 1);
    clear(); instruction_in = 32'h91ABCDEF; start = 1;
    repeat (7) @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    repeat (3) exp_q.push_back(32'h920104E0); chk_log("b2b_log");
    chk("b2b_done_cnt", done_cnt, 3);
    clear(); ack_delay = 3; instruction_in = 32'hA0123456; start = 1;
    @(negedge clk); start = 0;
    repeat (20) @(negedge clk);
    exp_q.push_back(32'hA1123456); exp_q.push_back(32'hA2123456); exp_q.push_back(32'hA3000010);
    chk_log("t2_log"); chk("t2_done_cnt", done_cnt, 1); chk("t2_sfm_cycles", sfm_cycles, 9);
    clear(); ack_delay = 0; instruction_in = 32'h55000000; start = 1;
    @(negedge clk); start = 0;
    chk("t3_e_ready", ready, 0); chk("t3_e_err", error, 0);
    @(negedge clk);
    chk("t3_e1_err", error, 1); chk("t3_e1_ready", ready, 1);
    @(negedge clk);
    chk("t3_e2_err", error, 0);
    repeat (2) @(negedge clk);
    chk("t3_err_cnt", err_cnt, 1); chk("t3_sfm_cycles", sfm_cycles, 0); chk("t3_done_cnt", done_cnt, 0);
    clear(); instruction_in = 32'hA0123456; start = 1;
    @(negedge clk); start = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = start_for_memory && uop_index == 2'd1;
    end
    chk("t4_reach_second", found, 1);
    flush = 1;
    @(negedge clk); flush = 0;
    chk("t4_sfm", start_for_memory, 0); chk("t4_ready", ready, 1);
    repeat (4) @(negedge clk);
    exp_q.push_back(32'hA1123456); chk_log("t4_log");
    chk("t4_done_cnt", done_cnt, 0); chk("t4_err_cnt", err_cnt, 0);
    clear(); ack_delay = 3; instruction_in = 32'h91000000; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); instruction_in = 32'hA0FFFFFF; start = 1;
    @(negedge clk); start = 0;
    repeat (8) @(negedge clk);
    exp_q.push_back(32'h920104E0); chk_log("t5_log"); chk("t5_done_cnt", done_cnt, 1);
    clear(); instruction_in = 32'hA0123456; start = 1;
    @(negedge clk); start = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = start_for_memory;
    end
    chk("t6_reach_send", found, 1);
    #2 reset = 0;
    #1;
    chk("t6_sfm", start_for_memory, 0); chk("t6_ready", ready, 1);
    chk("t6_out", instruction_out, 0); chk("t6_idx", uop_index, 0);
    chk("t6_done", done, 0); chk("t6_err", error, 0);
    @(negedge clk); reset = 1;
    repeat (3) @(negedge clk);
    chk("t6_after_ready", ready, 1); chk("t6_after_done_cnt", done_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
